// File: rtl/ss_done_gen.sv
// Purpose : responder end of start/done; runs a NUM_STEP job, one valid/ready step at a time, then pulses o_done.
// Latency : w_start sampled at edge k -> o_step_valid in cycle k+1; o_done the cycle after the last acceptance.
// Backpressure: o_step_valid/o_step_idx hold while i_step_ready=0; only i_abort or reset ends a stalled step.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_w_start                 job request level from the start-detect block
//   i_abort                   terminate the running job early
//   i_step_ready              datapath accepts the current step
//   o_step_valid, o_step_idx  step request and its index (0..NUM_STEP-1)
//   o_busy                    job in progress (ISSUE, GAP, DONE)
//   o_done, o_aborted         one-cycle done pulse, qualified by aborted
module ss_done_gen #(
    parameter int NUM_STEP = 8,
    parameter int STEP_GAP = 0,
    parameter int IDX_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_w_start,
    input  logic             i_abort,
    input  logic             i_step_ready,
    output logic             o_step_valid,
    output logic [IDX_W-1:0] o_step_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE,
        S_RELEASE
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STEP - 1);
    localparam logic [3:0]       GAP_LAST = (STEP_GAP > 0) ? 4'(STEP_GAP - 1) : 4'd0;
    localparam bit               HAS_GAP  = (STEP_GAP > 0);

    state_t           r_state;
    logic [3:0]       r_gap_cnt;
    logic             r_step_valid;
    logic [IDX_W-1:0] r_step_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;

    state_t           w_state_nxt;
    logic [3:0]       w_gap_cnt_nxt;
    logic             w_step_valid_nxt;
    logic [IDX_W-1:0] w_step_idx_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_aborted_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= 4'd0;
            r_step_valid <= 1'b0;
            r_step_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_step_valid <= w_step_valid_nxt;
            r_step_idx   <= w_step_idx_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    // Next-state logic also computes the next value of every output so that
    // all outputs come straight from flops.
    always_comb begin
        w_state_nxt      = r_state;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_step_valid_nxt = r_step_valid;
        w_step_idx_nxt   = r_step_idx;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_aborted_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_w_start) begin
                    w_step_idx_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    if (i_abort) begin
                        w_state_nxt   = S_DONE;
                        w_done_nxt    = 1'b1;
                        w_aborted_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = S_ISSUE;
                        w_step_valid_nxt = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // Abort wins over a same-cycle acceptance; the datapath still
                // owns that step, we just stop issuing.
                if (i_abort) begin
                    w_state_nxt      = S_DONE;
                    w_step_valid_nxt = 1'b0;
                    w_done_nxt       = 1'b1;
                    w_aborted_nxt    = 1'b1;
                end else if (i_step_ready) begin
                    if (r_step_idx == IDX_LAST) begin
                        // idx holds at the last value: no wrap inside a job
                        w_state_nxt      = S_DONE;
                        w_step_valid_nxt = 1'b0;
                        w_done_nxt       = 1'b1;
                    end else begin
                        w_step_idx_nxt = r_step_idx + IDX_W'(1);
                        if (HAS_GAP) begin
                            w_state_nxt      = S_GAP;
                            w_step_valid_nxt = 1'b0;
                            w_gap_cnt_nxt    = 4'd0;
                        end
                    end
                end
            end

            S_GAP: begin
                if (i_abort) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b1;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt      = S_ISSUE;
                    w_step_valid_nxt = 1'b1;
                    w_gap_cnt_nxt    = 4'd0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_RELEASE;
                w_busy_nxt  = 1'b0;
            end

            // Wait for the requester to drop w_start so a lingering level
            // cannot start a second job off the same request.
            S_RELEASE: begin
                if (!i_w_start) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt      = S_IDLE;
                w_step_valid_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
            end
        endcase
    end

    assign o_step_valid = r_step_valid;
    assign o_step_idx   = r_step_idx;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_aborted    = r_aborted;

endmodule

// File: tb/tb_ss_done_gen.sv
// Bench for ss_done_gen: three instances (4 steps/no gap, 3 steps/gap 2, 1 step)
// share one directed stimulus stream; a job-level model is compared every cycle,
// and per-scenario traces are checked against hand-derived patterns.
module tb_ss_done_gen;

    localparam int NS[3] = '{4, 3, 1};
    localparam int GP[3] = '{0, 2, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, w_start, abort, ready;
    logic       o_v [3];
    logic [7:0] o_i [3];
    logic       o_b [3];
    logic       o_d [3];
    logic       o_a [3];

    ss_done_gen #(.NUM_STEP(4), .STEP_GAP(0), .IDX_W(8)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_w_start(w_start), .i_abort(abort),
        .i_step_ready(ready), .o_step_valid(o_v[0]), .o_step_idx(o_i[0]),
        .o_busy(o_b[0]), .o_done(o_d[0]), .o_aborted(o_a[0]));
    ss_done_gen #(.NUM_STEP(3), .STEP_GAP(2), .IDX_W(8)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_w_start(w_start), .i_abort(abort),
        .i_step_ready(ready), .o_step_valid(o_v[1]), .o_step_idx(o_i[1]),
        .o_busy(o_b[1]), .o_done(o_d[1]), .o_aborted(o_a[1]));
    ss_done_gen #(.NUM_STEP(1), .STEP_GAP(0), .IDX_W(8)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_w_start(w_start), .i_abort(abort),
        .i_step_ready(ready), .o_step_valid(o_v[2]), .o_step_idx(o_i[2]),
        .o_busy(o_b[2]), .o_done(o_d[2]), .o_aborted(o_a[2]));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Job-level model: expected outputs plus "waiting for w_start to drop"
    // and the number of idle cycles left before the next step.
    typedef struct {
        bit valid;
        int idx;
        bit busy;
        bit done;
        bit ab;
        bit hold;
        int gap;
    } mst_t;

    mst_t ms [3];

    function automatic mst_t mstep(mst_t s, int n, int g, bit rn, bit ws, bit ab, bit rdy);
        mst_t t = s;
        if (!rn) begin
            t = '{valid: 0, idx: 0, busy: 0, done: 0, ab: 0, hold: 0, gap: 0};
        end else begin
            t.done = 0;
            t.ab   = 0;
            if (s.done) begin
                t.busy  = 0;
                t.valid = 0;
                t.hold  = 1;
            end else if (s.hold) begin
                if (!ws) t.hold = 0;
            end else if (!s.busy) begin
                if (ws) begin
                    t.busy = 1;
                    t.idx  = 0;
                    if (ab) begin t.done = 1; t.ab = 1; end
                    else t.valid = 1;
                end
            end else if (ab) begin
                t.valid = 0; t.done = 1; t.ab = 1;
            end else if (s.valid) begin
                if (rdy) begin
                    if (s.idx == n - 1) begin
                        t.valid = 0; t.done = 1;
                    end else begin
                        t.idx = s.idx + 1;
                        if (g > 0) begin t.valid = 0; t.gap = g; end
                    end
                end
            end else begin
                t.gap = s.gap - 1;
                if (t.gap == 0) t.valid = 1;
            end
        end
        return t;
    endfunction

    initial for (int i = 0; i < 3; i++) ms[i] = '{valid: 0, idx: 0, busy: 0, done: 0, ab: 0, hold: 0, gap: 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) ms[i] = mstep(ms[i], NS[i], GP[i], rst_n, w_start, abort, ready);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_valid", i), 32'(o_v[i]), 32'(ms[i].valid));
                chk($sformatf("u%0d_busy", i), 32'(o_b[i]), 32'(ms[i].busy));
                chk($sformatf("u%0d_done", i), 32'(o_d[i]), 32'(ms[i].done));
                chk($sformatf("u%0d_aborted", i), 32'(o_a[i]), 32'(ms[i].ab));
                if (ms[i].valid) chk($sformatf("u%0d_idx", i), 32'(o_i[i]), 32'(ms[i].idx));
            end
        end
    end

    // Per-scenario traces, bit c = value during cycle c (cycle c follows edge c-1).
    logic [15:0] rv [3];
    logic [15:0] rb [3];
    logic [15:0] rd [3];
    logic [15:0] ra [3];
    int          ridx [3][16];

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            rv[i] = '0; rb[i] = '0; rd[i] = '0; ra[i] = '0;
            for (int c = 0; c < 16; c++) ridx[i][c] = -1;
        end
    endtask

    // Drive inputs for cycle c, let edge c pass, record cycle c+1.
    task automatic step(input int c, input bit ws, input bit ab, input bit rdy, input bit rn);
        w_start = ws; abort = ab; ready = rdy; rst_n = rn;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rv[i][c+1] = o_v[i];
            rb[i][c+1] = o_b[i];
            rd[i][c+1] = o_d[i];
            ra[i][c+1] = o_a[i];
            ridx[i][c+1] = int'(o_i[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; w_start = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_valid", 32'(o_v[0]), 0);
        chk("rst_idx",   32'(o_i[0]), 0);
        chk("rst_busy",  32'(o_b[0]), 0);
        chk("rst_done",  32'(o_d[0]), 0);
        chk("rst_abort", 32'(o_a[0]), 0);

        // 1: ready=1, w_start raised at edge 0, lowered in cycle 6
        clr();
        for (int c = 0; c < 15; c++) step(c, c < 6, 1'b0, 1'b1, 1'b1);
        chk("s1_a_valid", 32'(rv[0]), 32'h001E);
        chk("s1_a_done",  32'(rd[0]), 32'h0020);
        chk("s1_a_abort", 32'(ra[0]), 32'h0000);
        chk("s1_a_busy",  32'(rb[0]), 32'h003E);
        for (int c = 1; c <= 4; c++) chk("s1_a_idx", 32'(ridx[0][c]), 32'(c - 1));
        chk("s1_b_valid", 32'(rv[1]), 32'h0092);
        chk("s1_b_done",  32'(rd[1]), 32'h0100);
        chk("s1_b_idx0",  32'(ridx[1][1]), 0);
        chk("s1_b_idx1",  32'(ridx[1][4]), 1);
        chk("s1_b_idx2",  32'(ridx[1][7]), 2);
        chk("s1_c_valid", 32'(rv[2]), 32'h0002);
        chk("s1_c_done",  32'(rd[2]), 32'h0004);
        chk("s1_c_busy",  32'(rb[2]), 32'h0006);

        // 2: backpressure, ready=0 in cycles 2..6; w_start drops in cycle 3
        clr();
        for (int c = 0; c < 15; c++) step(c, c < 3, 1'b0, !(c >= 2 && c <= 6), 1'b1);
        chk("s2_a_valid", 32'(rv[0]), 32'h03FE);
        for (int c = 2; c <= 7; c++) chk("s2_a_idx_hold", 32'(ridx[0][c]), 1);
        chk("s2_a_done",  32'(rd[0]), 32'h0400);
        chk("s2_b_valid", 32'(rv[1]), 32'h04F2);
        chk("s2_b_done",  32'(rd[1]), 32'h0800);
        chk("s2_c_done",  32'(rd[2]), 32'h0004);

        // 3: abort in cycle 3 (A on idx 2 with ready=1, B in gap, C in release), stray abort in cycle 6
        clr();
        for (int c = 0; c < 10; c++) step(c, c < 2, (c == 3) || (c == 6), 1'b1, 1'b1);
        chk("s3_a_valid", 32'(rv[0]), 32'h000E);
        chk("s3_a_idx2",  32'(ridx[0][3]), 2);
        chk("s3_a_done",  32'(rd[0]), 32'h0010);
        chk("s3_a_abort", 32'(ra[0]), 32'h0010);
        chk("s3_a_busy",  32'(rb[0]), 32'h001E);
        chk("s3_b_valid", 32'(rv[1]), 32'h0002);
        chk("s3_b_done",  32'(rd[1]), 32'h0010);
        chk("s3_b_abort", 32'(ra[1]), 32'h0010);
        chk("s3_c_done",  32'(rd[2]), 32'h0004);
        chk("s3_c_abort", 32'(ra[2]), 32'h0000);

        // 4: w_start held past done, dropped in cycles 9-10, re-raised from 11
        clr();
        for (int c = 0; c < 15; c++) step(c, (c <= 8) || (c >= 11), 1'b0, 1'b1, 1'b1);
        chk("s4_a_valid", 32'(rv[0]), 32'hF01E);
        chk("s4_a_done",  32'(rd[0]), 32'h0020);
        chk("s4_a_idx_restart", 32'(ridx[0][12]), 0);
        chk("s4_b_valid", 32'(rv[1]), 32'h9092);
        chk("s4_b_done",  32'(rd[1]), 32'h0100);
        chk("s4_c_valid", 32'(rv[2]), 32'h1002);
        chk("s4_c_done",  32'(rd[2]), 32'h2004);

        // 5: reset in cycle 2 (B in gap), then w_start=1 restarts from idx 0
        for (int c = 0; c < 2; c++) step(c, 1'b0, 1'b0, 1'b1, 1'b0);
        clr();
        for (int c = 0; c < 8; c++) step(c, 1'b1, 1'b0, 1'b1, c != 2);
        chk("s5_a_valid", 32'(rv[0]), 32'h00F6);
        chk("s5_a_busy",  32'(rb[0]), 32'h01F6);
        chk("s5_a_done",  32'(rd[0]), 32'h0100);
        chk("s5_a_idx_restart", 32'(ridx[0][4]), 0);
        chk("s5_b_valid", 32'(rv[1]), 32'h0092);
        chk("s5_b_busy",  32'(rb[1]), 32'h01F6);
        chk("s5_b_done",  32'(rd[1]), 32'h0000);
        chk("s5_b_idx_restart", 32'(ridx[1][4]), 0);
        chk("s5_c_done",  32'(rd[2]), 32'h0024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
